usb_rx_data_seq: RTL

USB_RX_DATA_SEQ -- requirements
Module: usb_rx_data_seq

---
 rtl/usb_rx_data_seq_pkg.sv | 55 +++++
 rtl/usb_rx_data_seq_crc16_chk.sv | 27 ++
 rtl/usb_rx_data_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_data_seq_pkg.sv
// Shared types and constants for the USB receive data sequencer.
// Holds FSM states, status codes, PID values and the CRC16 constants.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PID,
    ST_DATA,
    ST_HSK
  } state_t;

  typedef enum logic [2:0] {
    STAT_OK        = 3'd0,
    STAT_PID_ERR   = 3'd1,
    STAT_ALIGN_ERR = 3'd2,
    STAT_LEN_ERR   = 3'd3,
    STAT_CRC_ERR   = 3'd4,
    STAT_ABORT     = 3'd5
  } status_t;

  typedef enum logic [1:0] {
    PK_DATA,
    PK_HSK,
    PK_ERR
  } pid_kind_t;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_DATA2 = 4'b0111;
  localparam logic [3:0] PID_MDATA = 4'b1111;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

  // Payload limit plus the two CRC bytes.
  localparam logic [10:0] MAX_BYTES = 11'd1026;

  function automatic pid_kind_t classify_pid(input logic [7:0] b);
    pid_kind_t k;
    k = PK_ERR;
    if (b[7:4] == ~b[3:0]) begin
      case (b[3:0])
        PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA: k = PK_DATA;
        PID_ACK, PID_NAK, PID_STALL:                k = PK_HSK;
        default:                                    k = PK_ERR;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/usb_rx_data_seq_crc16_chk.sv
// Bit-serial CRC16 checker; the register is reloaded on clr and advances on en.
module crc16_chk
  import usb_rx_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en,
  input  logic        clr,
  input  logic        din,
  output logic [15:0] rem
);

  logic fb;

  assign fb = din ^ rem[15];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem <= CRC16_INIT;
    end else if (clr) begin
      rem <= CRC16_INIT;
    end else if (en) begin
      rem <= {rem[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/usb_rx_data_seq.sv
// USB receive sequencer: PID decode, payload delay buffer, CRC/length checks.
//
// state | meaning
// IDLE  | waiting for first bit; also swallows bits after a bad PID until EOP
// PID   | collecting the 8 PID bits
// DATA  | payload + CRC bits feed the CRC and the 2-byte delay buffer
// HSK   | handshake received; only EOP is legal
module usb_rx_data_seq
  import usb_rx_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_valid,
  input  logic       rx_bit,
  input  logic       rx_eop,
  input  logic       rx_abort,
  output logic [3:0] pid,
  output logic       pid_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       pkt_done,
  output logic [2:0] status,
  output logic       busy
);

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  buf0_q, buf0_d, buf1_q, buf1_d;
  logic        discard_q, discard_d;
  logic        hsk_extra_q, hsk_extra_d;
  logic [3:0]  pid_d;
  logic        pid_valid_d, byte_valid_d, pkt_done_d;
  logic [7:0]  byte_out_d;
  logic [2:0]  status_d;

  logic        bit_in, term;
  status_t     term_status;
  logic [7:0]  byte_now;
  logic [10:0] cnt_inc;
  logic [15:0] crc_rem;

  // A bit arriving together with EOP/abort is dropped.
  assign bit_in   = rx_valid && !rx_eop && !rx_abort;
  assign byte_now = {rx_bit, shreg_q[7:1]};
  assign cnt_inc  = (byte_cnt_q == 11'd2047) ? byte_cnt_q : byte_cnt_q + 11'd1;
  assign busy     = (state_q != ST_IDLE);

  crc16_chk u_crc (
    .clock   (clock),
    .reset_n (reset_n),
    .en      ((state_q == ST_DATA) && bit_in),
    .clr     (state_q == ST_IDLE),
    .din     (rx_bit),
    .rem     (crc_rem)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    shreg_d      = shreg_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    discard_d    = discard_q;
    hsk_extra_d  = hsk_extra_q;
    pid_d        = pid;
    byte_out_d   = byte_out;
    status_d     = status;
    pid_valid_d  = 1'b0;
    byte_valid_d = 1'b0;
    pkt_done_d   = 1'b0;
    term         = 1'b0;
    term_status  = STAT_OK;

    case (state_q)
      ST_IDLE: begin
        if (discard_q) begin
          if (rx_abort) begin
            term        = 1'b1;
            term_status = STAT_ABORT;
          end else if (rx_eop) begin
            term        = 1'b1;
            term_status = STAT_PID_ERR;
          end
        end else if (bit_in) begin
          state_d   = ST_PID;
          shreg_d   = {rx_bit, 7'd0};
          bit_cnt_d = 3'd1;
        end
      end
      ST_PID: begin
        if (rx_abort) begin
          term        = 1'b1;
          term_status = STAT_ABORT;
        end else if (rx_eop) begin
          term        = 1'b1;
          term_status = STAT_PID_ERR;
        end else if (rx_valid) begin
          shreg_d   = byte_now;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            case (classify_pid(byte_now))
              PK_DATA: begin
                state_d     = ST_DATA;
                pid_d       = byte_now[3:0];
                pid_valid_d = 1'b1;
              end
              PK_HSK: begin
                state_d     = ST_HSK;
                pid_d       = byte_now[3:0];
                pid_valid_d = 1'b1;
              end
              default: begin
                state_d   = ST_IDLE;
                discard_d = 1'b1;
              end
            endcase
          end
        end
      end
      ST_DATA: begin
        if (rx_abort) begin
          term        = 1'b1;
          term_status = STAT_ABORT;
        end else if (rx_eop) begin
          term = 1'b1;
          if (bit_cnt_q != 3'd0)             term_status = STAT_ALIGN_ERR;
          else if (byte_cnt_q < 11'd2)       term_status = STAT_LEN_ERR;
          else if (byte_cnt_q > MAX_BYTES)   term_status = STAT_LEN_ERR;
          else if (crc_rem != CRC16_RESIDUE) term_status = STAT_CRC_ERR;
          else                               term_status = STAT_OK;
        end else if (rx_valid) begin
          shreg_d   = byte_now;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_cnt_d = cnt_inc;
            buf0_d     = buf1_q;
            buf1_d     = byte_now;
            // Oldest byte leaves only once two newer bytes exist behind it.
            if (cnt_inc >= 11'd3 && cnt_inc <= MAX_BYTES) begin
              byte_out_d   = buf0_q;
              byte_valid_d = 1'b1;
            end
          end
        end
      end
      ST_HSK: begin
        if (rx_abort) begin
          term        = 1'b1;
          term_status = STAT_ABORT;
        end else if (rx_eop) begin
          term        = 1'b1;
          term_status = hsk_extra_q ? STAT_LEN_ERR : STAT_OK;
        end else if (rx_valid) begin
          hsk_extra_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (term) begin
      state_d     = ST_IDLE;
      pkt_done_d  = 1'b1;
      status_d    = term_status;
      bit_cnt_d   = 3'd0;
      byte_cnt_d  = 11'd0;
      shreg_d     = 8'd0;
      buf0_d      = 8'd0;
      buf1_d      = 8'd0;
      discard_d   = 1'b0;
      hsk_extra_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 11'd0;
      shreg_q     <= 8'd0;
      buf0_q      <= 8'd0;
      buf1_q      <= 8'd0;
      discard_q   <= 1'b0;
      hsk_extra_q <= 1'b0;
      pid         <= 4'd0;
      pid_valid   <= 1'b0;
      byte_out    <= 8'd0;
      byte_valid  <= 1'b0;
      pkt_done    <= 1'b0;
      status      <= 3'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shreg_q     <= shreg_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      discard_q   <= discard_d;
      hsk_extra_q <= hsk_extra_d;
      pid         <= pid_d;
      pid_valid   <= pid_valid_d;
      byte_out    <= byte_out_d;
      byte_valid  <= byte_valid_d;
      pkt_done    <= pkt_done_d;
      status      <= status_d;
    end
  end

endmodule
